// File: rtl/fifo_vector_reader.sv
// ----------------------------------------------------------------------------
// fifo_vector_reader
//
// Drain side of the vector FIFO in the QR decomposition datapath. It pops
// VECTOR_LEN consecutive words from a show-ahead FIFO and packs them into one
// parallel vector. The vector is then offered downstream over a valid/ready
// handshake. This block makes every pop decision, so the FIFO is never read
// while it is empty.
//
// Parameters
//   DATA_WIDTH  width of one FIFO word (one matrix element)
//   VECTOR_LEN  words per vector, 2..16
//   CNT_WIDTH   width of the completed-vector counter
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   flush        synchronous discard of any partial or held vector
//   fifo_empty   FIFO empty flag
//   fifo_r_data  FIFO head word, valid whenever fifo_empty is low
//   fifo_rd      pop strobe, one word consumed per cycle high
//   vec_data     assembled vector, element 0 (first popped) in the LSBs
//   vec_valid    vec_data holds a complete vector
//   vec_ready    downstream accepts the vector
//   busy         a vector is partly collected or is being held
//   vec_count    vectors accepted downstream, wraps silently
// ----------------------------------------------------------------------------
module fifo_vector_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int VECTOR_LEN = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            fifo_r_data,
    output logic                             fifo_rd,
    output logic [VECTOR_LEN*DATA_WIDTH-1:0] vec_data,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             vec_count
);

    localparam int IDX_W = $clog2(VECTOR_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // A pop is suppressed in reset and flush cycles, so no FIFO word is lost
    // to a vector that is about to be discarded.
    assign fifo_rd = (state == COLLECT) & ~fifo_empty & ~flush & ~reset;

    assign busy = (state == HOLD) | (idx != '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge and evaluation order
    // inside the block does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            idx       <= '0;
            vec_valid <= 1'b0;
            vec_count <= '0;
            // NOTE: the vector register is datapath storage, but its reset
            // value is visible on the port, so it is cleared as well.
            vec_data  <= '0;
        end else if (flush) begin
            // Any slot contents left behind are overwritten before the next
            // vec_valid, so only the control state is cleared here.
            state     <= COLLECT;
            idx       <= '0;
            vec_valid <= 1'b0;
        end else if (state == COLLECT) begin
            if (!fifo_empty) begin
                for (int i = 0; i < VECTOR_LEN; i++) begin
                    if (idx == IDX_W'(i)) begin
                        vec_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_r_data;
                    end
                end
                if (idx == LAST_IDX) begin
                    idx       <= '0;
                    state     <= HOLD;
                    vec_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end else begin
            // HOLD: vec_data is frozen until downstream takes it.
            if (vec_ready) begin
                state     <= COLLECT;
                vec_valid <= 1'b0;
                vec_count <= vec_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_vector_reader.md
# fifo_vector_reader

Drain side of the vector FIFO in the QR decomposition datapath. Pops `VECTOR_LEN` consecutive words from a show-ahead FIFO (`rd`/`empty`/`r_data` style port) and assembles them into one parallel vector. It presents the vector to the downstream column/normalisation unit through a valid/ready handshake. The block owns all pop decisions, so the FIFO never sees `rd` while empty.

## Interface
- `DATA_WIDTH`, 32, width of one FIFO word (one matrix element).
- `VECTOR_LEN`, 3, words per vector; legal range 2..16.
- `CNT_WIDTH`, 16, width of the completed-vector counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous; discards any partially collected vector.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data`  in  DATA_WIDTH  FIFO head word; valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_rd`  out  1  pop strobe; one word consumed per cycle high.
- `vec_data`  out  VECTOR_LEN*DATA_WIDTH  assembled vector; element 0 (first popped) in bits [DATA_WIDTH-1:0].
- `vec_valid`  out  1  `vec_data` holds a complete vector.
- `vec_ready`  in  1  downstream accepts the vector.
- `busy`  out  1  at least one element of the current vector has been collected, or a vector is held.
- `vec_count`  out  CNT_WIDTH  number of vectors accepted downstream, wraps modulo 2^CNT_WIDTH.

## Operation
- Two states: COLLECT and HOLD. Reset state is COLLECT.
- Element index `idx` has width clog2(VECTOR_LEN) and resets to 0.
- `fifo_rd` is combinational: `fifo_rd` = (state==COLLECT) & ~`fifo_empty` & ~`flush` & ~`reset`.
- COLLECT, on a pop:
  - `fifo_r_data` is written into vector slot `idx`.
  - If `idx` < VECTOR_LEN-1, `idx` increments.
  - If `idx` == VECTOR_LEN-1, `idx` returns to 0, the state becomes HOLD and `vec_valid` is set.
- COLLECT with `fifo_empty`=1: idle, no state change. A partial vector waits indefinitely.
- HOLD:
  - `vec_valid`=1, and `vec_data` is stable until the handshake.
  - No pops occur.
  - When `vec_valid` & `vec_ready` in a cycle: the next state is COLLECT, `vec_valid` drops and `vec_count` increments by 1.
- `vec_ready` is ignored in COLLECT.
- `flush`:
  - In COLLECT: `idx` returns to 0 and no pop occurs that cycle. Slot contents are don't-care but `vec_data` is not observable as valid.
  - In HOLD: the held vector is discarded, `vec_valid` drops, the state becomes COLLECT and `vec_count` is not incremented, even if `vec_ready`=1 in the same cycle.
- `busy` = (state==HOLD) | (`idx` != 0).
- `reset` has priority over `flush`, which has priority over the handshake and pops.

## Timing
- Reset values: state COLLECT, `idx`=0, `vec_data`=0, `vec_valid`=0, `vec_count`=0, `busy`=0, `fifo_rd`=0.
- Reset asserted mid-vector or mid-HOLD clears everything on that edge; no pop is issued in a reset cycle.
- Latency:
  - `vec_valid` rises on the edge that captures the last element. It is visible the cycle after the VECTOR_LEN-th pop.
  - With a never-empty FIFO, pops occur on VECTOR_LEN consecutive cycles and `vec_valid` is high the next cycle.
- Throughput:
  - With `vec_ready` tied high, one vector every VECTOR_LEN+1 cycles.
  - `fifo_rd` is low for exactly one cycle between vectors, the HOLD cycle.
- FIFO gaps (`fifo_empty` toggling) stall collection without losing or duplicating words; each word is popped exactly once.
- `vec_data` changes only on pop edges in COLLECT and never while `vec_valid`=1.
- `vec_count` wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Test plan
- Reset/idle: hold `reset` 3 cycles, then `fifo_empty`=1 for 10 cycles -> all outputs 0, `fifo_rd` never high.
- Back-to-back: VECTOR_LEN=3, FIFO preloaded with 0x11,0x22,0x33,0x44,0x55,0x66, `vec_ready`=1 -> two vectors {0x33,0x22,0x11} and {0x66,0x55,0x44} (MSB..LSB); `vec_valid` high on cycles 4 and 8 after the first pop cycle 1; `vec_count`=2.
- Backpressure: complete vector 0xA,0xB,0xC with `vec_ready`=0 for 5 cycles -> `vec_valid` and `vec_data` stable and `fifo_rd`=0 throughout, even though the FIFO holds more words. Raise `vec_ready` -> one handshake, `vec_count` increments by 1.
- Sparse FIFO: words arrive with `fifo_empty` high for 2 cycles between each -> the same vector contents as the dense case, exactly 3 pops per vector, `busy`=1 during the gaps.
- Flush: pop 0x1,0x2, then pulse `flush` -> `idx`=0, `busy`=0; the next 0x7,0x8,0x9 yield a vector {0x9,0x8,0x7}. Also pulse `flush` together with `vec_ready` in HOLD -> `vec_valid` drops and `vec_count` is unchanged.
- Reset mid-operation: assert `reset` after 2 pops, and separately during HOLD -> all reset values next cycle, no pop in the reset cycle, and the next vector starts at slot 0.
